// File: rtl/operand_unloader.sv
// Captures four operands (2x16, 2x32) on start and streams them out as six
// 16-bit beats over valid/ready, followed by a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for start; outputs quiet
// SEND   | out_valid high, beat out_idx presented until accepted
// DONE   | one-cycle completion pulse, then back to IDLE
module operand_unloader #(
    parameter bit LSW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] data_in1,
    input  logic [15:0] data_in2,
    input  logic [31:0] data_in3,
    input  logic [31:0] data_in4,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  out_idx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] d1_q, d1_d;
    logic [15:0] d2_q, d2_d;
    logic [31:0] d3_q, d3_d;
    logic [31:0] d4_q, d4_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] data_q, data_d;

    function automatic logic [15:0] beat_sel(
        input logic [2:0]  idx,
        input logic [15:0] a,
        input logic [15:0] b,
        input logic [31:0] c,
        input logic [31:0] d
    );
        logic [15:0] r;
        case (idx)
            3'd0:    r = a;
            3'd1:    r = b;
            3'd2:    r = LSW_FIRST ? c[15:0]  : c[31:16];
            3'd3:    r = LSW_FIRST ? c[31:16] : c[15:0];
            3'd4:    r = LSW_FIRST ? d[15:0]  : d[31:16];
            3'd5:    r = LSW_FIRST ? d[31:16] : d[15:0];
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        d3_d    = d3_q;
        d4_d    = d4_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    d1_d    = data_in1;
                    d2_d    = data_in2;
                    d3_d    = data_in3;
                    d4_d    = data_in4;
                    idx_d   = 3'd0;
                    data_d  = data_in1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        state_d = S_DONE;
                    end else begin
                        // Next beat is looked up from the captured copies so
                        // late input changes cannot leak into the stream.
                        idx_d  = idx_q + 3'd1;
                        data_d = beat_sel(idx_q + 3'd1, d1_q, d2_q, d3_q, d4_q);
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            d4_q    <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            d3_q    <= d3_d;
            d4_q    <= d4_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign out_data  = data_q;
    assign out_idx   = idx_q;
    assign out_valid = (state_q == S_SEND);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_operand_unloader.sv
// Scoreboard bench for operand_unloader: both beat orders run side by side
// against a cycle model of the IDLE/SEND/DONE sequence.
module tb_operand_unloader;

    localparam int M_IDLE = 0;
    localparam int M_SEND = 1;
    localparam int M_DONE = 2;

    logic        clk = 1'b0;
    logic        rst, start, out_ready;
    logic [15:0] data_in1, data_in2;
    logic [31:0] data_in3, data_in4;

    logic [15:0] out_data_l, out_data_m;
    logic [2:0]  out_idx_l, out_idx_m;
    logic        out_valid_l, out_valid_m, busy_l, busy_m, done_l, done_m;

    int n_cmp = 0;
    int n_err = 0;

    int          m_state = M_IDLE;
    int          m_cnt   = 0;
    logic [15:0] q_l[$];
    logic [15:0] q_m[$];
    bit          mon_en  = 1'b0;
    int          rdy_mode = 0;
    int          cyc = 0;
    bit [5:0]    rdy_pat = 6'b101001;  // bit0 first: 1,0,0,1,0,1

    always #5 clk = ~clk;

    operand_unloader #(.LSW_FIRST(1'b1)) u_dut_lsw (
        .clk(clk), .rst(rst), .start(start),
        .data_in1(data_in1), .data_in2(data_in2),
        .data_in3(data_in3), .data_in4(data_in4),
        .out_data(out_data_l), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_idx(out_idx_l), .busy(busy_l), .done(done_l)
    );

    operand_unloader #(.LSW_FIRST(1'b0)) u_dut_msw (
        .clk(clk), .rst(rst), .start(start),
        .data_in1(data_in1), .data_in2(data_in2),
        .data_in3(data_in3), .data_in4(data_in4),
        .out_data(out_data_m), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_idx(out_idx_m), .busy(busy_m), .done(done_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_beat(input bit lsw, input logic [15:0] a,
                                             input logic [15:0] b, input logic [31:0] c,
                                             input logic [31:0] d, input int i);
        case (i)
            0:       return a;
            1:       return b;
            2:       return lsw ? c[15:0]  : c[31:16];
            3:       return lsw ? c[31:16] : c[15:0];
            4:       return lsw ? d[15:0]  : d[31:16];
            default: return lsw ? d[31:16] : d[15:0];
        endcase
    endfunction

    // Ready generator: always high, fixed toggle pattern, or random.
    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = rdy_pat[cyc % 6];
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Model and scoreboard: check this cycle's outputs, then advance the model
    // across the coming rising edge using the inputs held now.
    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_lsw", 32'(out_valid_l), 32'(m_state == M_SEND));
            check("valid_msw", 32'(out_valid_m), 32'(m_state == M_SEND));
            check("busy_lsw",  32'(busy_l),      32'(m_state != M_IDLE));
            check("busy_msw",  32'(busy_m),      32'(m_state != M_IDLE));
            check("done_lsw",  32'(done_l),      32'(m_state == M_DONE));
            check("done_msw",  32'(done_m),      32'(m_state == M_DONE));
            check("idx_lsw",   32'(out_idx_l),   32'(m_cnt));
            check("idx_msw",   32'(out_idx_m),   32'(m_cnt));
            if (m_state == M_SEND) begin
                if (q_l.size() == 0 || q_m.size() == 0) begin
                    check("scoreboard_empty", 32'(q_l.size()), 32'd6);
                end else begin
                    check("data_lsw", 32'(out_data_l), 32'(q_l[0]));
                    check("data_msw", 32'(out_data_m), 32'(q_m[0]));
                end
            end
            if (rst) begin
                m_state = M_IDLE;
                m_cnt   = 0;
                q_l.delete();
                q_m.delete();
            end else begin
                case (m_state)
                    M_IDLE: if (start) begin
                        for (int i = 0; i < 6; i++) begin
                            q_l.push_back(exp_beat(1'b1, data_in1, data_in2, data_in3, data_in4, i));
                            q_m.push_back(exp_beat(1'b0, data_in1, data_in2, data_in3, data_in4, i));
                        end
                        m_cnt   = 0;
                        m_state = M_SEND;
                    end
                    M_SEND: if (out_ready) begin
                        if (q_l.size() > 0) void'(q_l.pop_front());
                        if (q_m.size() > 0) void'(q_m.pop_front());
                        if (m_cnt == 5) begin
                            m_cnt   = 0;
                            m_state = M_DONE;
                        end else begin
                            m_cnt++;
                        end
                    end
                    default: m_state = M_IDLE;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 300; i++) begin
            if (m_state == M_IDLE) break;
            tick();
        end
        if (i == 300) check("timeout_idle", 32'(m_state), 32'(M_IDLE));
        tick();
    endtask

    task automatic wait_cnt(input int n);
        int i;
        for (i = 0; i < 300; i++) begin
            if (m_state == M_SEND && m_cnt == n) break;
            tick();
        end
        if (i == 300) check("timeout_cnt", 32'(m_cnt), 32'(n));
    endtask

    task automatic run_one(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] c, input logic [31:0] d);
        data_in1 = a; data_in2 = b; data_in3 = c; data_in4 = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        data_in1 = '0; data_in2 = '0; data_in3 = '0; data_in4 = '0;
        tick();
        mon_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_data_lsw", 32'(out_data_l), 32'd0);
        check("rst_data_msw", 32'(out_data_m), 32'd0);
        tick();

        // Basic stream, ready held high
        rdy_mode = 0;
        run_one(16'h0008, 16'h4008, 32'd10, 32'd20);

        // Same data under toggling ready
        rdy_mode = 1;
        run_one(16'h0008, 16'h4008, 32'd10, 32'd20);

        // Half ordering
        rdy_mode = 0;
        run_one(16'hA5A5, 16'h5A5A, 32'h1234_5678, 32'hDEAD_BEEF);

        // Start and data changes during SEND must be ignored
        data_in1 = 16'h1111; data_in2 = 16'h2222;
        data_in3 = 32'h3333_4444; data_in4 = 32'h5555_6666;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cnt(3);
        start = 1'b1; data_in1 = 16'hFFFF; data_in3 = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        wait_idle();

        // Reset mid-transfer, then a fresh full stream
        data_in1 = 16'h0101; data_in2 = 16'h0202;
        data_in3 = 32'h0303_0404; data_in4 = 32'h0505_0606;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_cnt(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_idle();
        run_one(16'h7777, 16'h8888, 32'h9999_AAAA, 32'hBBBB_CCCC);

        // Start held high: back-to-back transfers
        data_in1 = 16'hC001; data_in2 = 16'hC002;
        data_in3 = 32'hC003_C004; data_in4 = 32'hC005_C006;
        start = 1'b1;
        repeat (30) tick();
        start = 1'b0;
        wait_idle();

        // Random data and random ready
        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin
            run_one(16'($urandom), 16'($urandom), $urandom, $urandom);
        end
        rdy_mode = 0;
        tick();

        check("scoreboard_left_lsw", 32'(q_l.size()), 32'd0);
        check("scoreboard_left_msw", 32'(q_m.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
